// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK levels, byte length and
// R/W bit encodings used by both the target and the controller side.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_REG_ADDR,
        ST_REG_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_LOAD,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_e;

    localparam logic       ACK           = 1'b0;
    localparam logic       NACK          = 1'b1;
    localparam logic [3:0] BITS_PER_BYTE = 4'd8;
    localparam logic       RW_WRITE      = 1'b0;
    localparam logic       RW_READ       = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Pad-line synchronizer followed by a registered rise/fall edge detector.
// Resets to the idle-high bus level so reset release never fakes an edge.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/i2c_target_sync.sv
// System-clocked I2C target exposing a byte-wide register-file interface.
// Bursts auto-increment the register pointer; SDA is open-drain (pull low / release).
module i2c_target_sync
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h68,
    parameter int         SYNC_STAGES    = 2
) (
    input  logic       Clk_In,
    input  logic       Reset_In,
    input  logic       SCL_In,
    input  logic       SDA_In,
    output logic       SDA_Drive_Low_Out,
    output logic [7:0] Reg_Address_Out,
    output logic [7:0] Reg_Write_Data_Out,
    output logic       Reg_Write_Enable_Out,
    output logic       Reg_Read_Enable_Out,
    input  logic [7:0] Reg_Read_Data_In,
    output logic       Busy_Out,
    output logic       Stop_Detect_Out,
    output i2c_state_e Dbg_State_Out
);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop, w_byte_done, w_addr_match;
    logic w_read_en, w_sda_low_next;

    i2c_state_e r_state, w_state_next;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift, r_ptr, r_wdata;
    logic       r_load_phase, r_sda_low, r_wr_en, r_busy, r_stop_pulse;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .i_clk(Clk_In), .i_rst(Reset_In), .i_line(SCL_In),
        .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .i_clk(Clk_In), .i_rst(Reset_In), .i_line(SDA_In),
        .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    assign w_start      = w_sda_fall & w_scl;
    assign w_stop       = w_sda_rise & w_scl;
    assign w_byte_done  = (r_bit_cnt == BITS_PER_BYTE);
    assign w_addr_match = (r_shift[7:1] == DEVICE_ADDRESS);

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Reads leave DEV_ACK / RD_ACK on the SCL rise so the byte is loaded before the next fall.
    always_comb begin
        w_state_next = r_state;
        if (w_stop) begin
            w_state_next = ST_IDLE;
        end else if (w_start) begin
            w_state_next = ST_DEV_ADDR;
        end else begin
            case (r_state)
                ST_DEV_ADDR: if (w_scl_fall && w_byte_done)
                                 w_state_next = w_addr_match ? ST_DEV_ACK : ST_IGNORE;
                ST_DEV_ACK:  if (r_shift[0] == RW_READ) begin
                                 if (w_scl_rise) w_state_next = ST_RD_LOAD;
                             end else if (w_scl_fall) begin
                                 w_state_next = ST_REG_ADDR;
                             end
                ST_REG_ADDR: if (w_scl_fall && w_byte_done) w_state_next = ST_REG_ACK;
                ST_REG_ACK:  if (w_scl_fall) w_state_next = ST_WR_DATA;
                ST_WR_DATA:  if (w_scl_fall && w_byte_done) w_state_next = ST_WR_ACK;
                ST_WR_ACK:   if (w_scl_fall) w_state_next = ST_WR_DATA;
                ST_RD_LOAD:  if (r_load_phase) w_state_next = ST_RD_DATA;
                ST_RD_DATA:  if (w_scl_fall && w_byte_done) w_state_next = ST_RD_ACK;
                ST_RD_ACK:   if (w_scl_rise) w_state_next = (w_sda == ACK) ? ST_RD_LOAD : ST_IGNORE;
                default:     ;
            endcase
        end
    end

    always_comb begin
        w_read_en      = (r_state == ST_RD_LOAD) && !r_load_phase;
        w_sda_low_next = r_sda_low;
        if (w_start || w_stop) begin
            w_sda_low_next = 1'b0;
        end else if (w_scl_fall) begin
            case (r_state)
                ST_DEV_ADDR:             w_sda_low_next = w_byte_done && w_addr_match;
                ST_REG_ADDR, ST_WR_DATA: w_sda_low_next = w_byte_done;
                ST_RD_DATA:              w_sda_low_next = w_byte_done ? 1'b0 : ~r_shift[7];
                default:                 w_sda_low_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_ptr        <= '0;
            r_wdata      <= '0;
            r_load_phase <= 1'b0;
            r_sda_low    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_stop_pulse <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_stop_pulse <= w_stop;
            r_sda_low    <= w_sda_low_next;
            if (w_stop || w_start) begin
                r_bit_cnt    <= '0;
                r_load_phase <= 1'b0;
                if (w_stop) r_busy <= 1'b0;
            end else begin
                case (r_state)
                    ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
                        if (w_scl_rise && !w_byte_done) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && w_byte_done) begin
                            r_bit_cnt <= '0;
                            if (r_state == ST_DEV_ADDR && w_addr_match) r_busy <= 1'b1;
                            if (r_state == ST_REG_ADDR) r_ptr <= r_shift;
                            if (r_state == ST_WR_DATA) begin
                                r_wr_en <= 1'b1;
                                r_wdata <= r_shift;
                            end
                        end
                    end
                    ST_WR_ACK: if (w_scl_fall) r_ptr <= r_ptr + 8'd1;
                    ST_RD_LOAD: begin
                        r_load_phase <= !r_load_phase;
                        if (r_load_phase) begin
                            r_shift   <= Reg_Read_Data_In;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_RD_DATA: if (w_scl_fall) begin
                        if (w_byte_done) begin
                            r_bit_cnt <= '0;
                        end else begin
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    ST_RD_ACK: if (w_scl_rise && w_sda == ACK) r_ptr <= r_ptr + 8'd1;
                    default: ;
                endcase
            end
        end
    end

    assign SDA_Drive_Low_Out    = r_sda_low;
    assign Reg_Address_Out      = r_ptr;
    assign Reg_Write_Data_Out   = r_wdata;
    assign Reg_Write_Enable_Out = r_wr_en;
    assign Reg_Read_Enable_Out  = w_read_en;
    assign Busy_Out             = r_busy;
    assign Stop_Detect_Out      = r_stop_pulse;
    assign Dbg_State_Out        = r_state;

endmodule

// File: tb/tb_i2c_target_sync.sv
// Directed bench for i2c_target_sync: an I2C controller model on a wired-AND SDA,
// a combinational register file, and queues of expected register-interface activity.
module tb_i2c_target_sync;
    import i2c_pkg::*;

    localparam int Q = 5;  // clocks per quarter SCL period (bit = 20 clocks)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_ctrl = 1'b1;
    logic       sda_bus;
    logic       sda_low;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, busy, stop_det;
    i2c_state_e dbg_state;

    logic [7:0]  mem [256];
    logic [15:0] exp_wr_q [$];
    logic [7:0]  exp_rd_q [$];
    logic [7:0]  exp_data_q [$];

    int n_checks = 0;
    int n_fail = 0;
    int wr_cnt = 0, rd_cnt = 0, stop_cnt = 0, drv_cnt = 0;

    assign sda_bus   = sda_ctrl & ~sda_low;
    assign reg_rdata = mem[reg_addr];

    i2c_target_sync dut (
        .Clk_In(clk), .Reset_In(rst), .SCL_In(scl), .SDA_In(sda_bus),
        .SDA_Drive_Low_Out(sda_low), .Reg_Address_Out(reg_addr),
        .Reg_Write_Data_Out(reg_wdata), .Reg_Write_Enable_Out(reg_we),
        .Reg_Read_Enable_Out(reg_re), .Reg_Read_Data_In(reg_rdata),
        .Busy_Out(busy), .Stop_Detect_Out(stop_det), .Dbg_State_Out(dbg_state)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: register-interface pulses are matched against queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (sda_low) drv_cnt++;
            if (stop_det) stop_cnt++;
            if (reg_we) begin
                wr_cnt++;
                check("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
                if (exp_wr_q.size() != 0)
                    check("wr_addr_data", {16'd0, reg_addr, reg_wdata}, {16'd0, exp_wr_q.pop_front()});
            end
            if (reg_re) begin
                rd_cnt++;
                check("rd_expected", 32'(exp_rd_q.size() != 0), 32'd1);
                if (exp_rd_q.size() != 0)
                    check("rd_addr", {24'd0, reg_addr}, {24'd0, exp_rd_q.pop_front()});
            end
        end
    end

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_ctrl = 1'b1; scl = 1'b1; wait_q();
        sda_ctrl = 1'b0; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic i2c_rep_start();
        sda_ctrl = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        sda_ctrl = 1'b0; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        scl = 1'b0; wait_q();
        sda_ctrl = 1'b0; wait_q();
        scl = 1'b1; wait_q();
        sda_ctrl = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic send_bit(input logic b, output logic sampled);
        sda_ctrl = b; wait_q();
        scl = 1'b1; wait_q();
        sampled = sda_bus;
        wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_out, output logic [7:0] data);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            data[i] = s;
        end
        send_bit(ack_out, s);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rdata;
        int wr0, rd0, st0, dv0;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check("rst_sda", 32'(sda_low), 32'd0);
        check("rst_ptr", 32'(reg_addr), 32'h00);
        check("rst_we", 32'(reg_we), 32'd0);
        check("rst_re", 32'(reg_re), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // STOP while idle only pulses the stop detector
        st0 = stop_cnt;
        i2c_stop();
        check("idle_stop_pulse", 32'(stop_cnt - st0), 32'd1);
        check("idle_stop_state", 32'(dbg_state), 32'(ST_IDLE));

        // Single write 0x10 <= 0xA5
        wr0 = wr_cnt; st0 = stop_cnt;
        i2c_start();
        send_byte(8'hD0, ack); check("wr1_dev_ack", 32'(ack), 32'(ACK));
        check("wr1_busy", 32'(busy), 32'd1);
        send_byte(8'h10, ack); check("wr1_reg_ack", 32'(ack), 32'(ACK));
        exp_wr_q.push_back({8'h10, 8'hA5});
        send_byte(8'hA5, ack); check("wr1_data_ack", 32'(ack), 32'(ACK));
        i2c_stop();
        check("wr1_pulses", 32'(wr_cnt - wr0), 32'd1);
        check("wr1_stop", 32'(stop_cnt - st0), 32'd1);
        check("wr1_busy_clr", 32'(busy), 32'd0);
        check("wr1_ptr_inc", 32'(reg_addr), 32'h11);

        // Burst write across the pointer wrap
        wr0 = wr_cnt;
        i2c_start();
        send_byte(8'hD0, ack); check("burst_dev_ack", 32'(ack), 32'(ACK));
        send_byte(8'hFE, ack); check("burst_reg_ack", 32'(ack), 32'(ACK));
        exp_wr_q.push_back({8'hFE, 8'h11}); send_byte(8'h11, ack);
        check("burst_ack0", 32'(ack), 32'(ACK));
        exp_wr_q.push_back({8'hFF, 8'h22}); send_byte(8'h22, ack);
        check("burst_ack1", 32'(ack), 32'(ACK));
        exp_wr_q.push_back({8'h00, 8'h33}); send_byte(8'h33, ack);
        check("burst_ack2", 32'(ack), 32'(ACK));
        i2c_stop();
        check("burst_pulses", 32'(wr_cnt - wr0), 32'd3);
        check("burst_ptr", 32'(reg_addr), 32'h01);

        // Write pointer, repeated START, read two bytes (ACK then NACK)
        mem[8'h20] = 8'h5A; exp_data_q.push_back(8'h5A);
        mem[8'h21] = 8'hC3; exp_data_q.push_back(8'hC3);
        wr0 = wr_cnt; rd0 = rd_cnt;
        i2c_start();
        send_byte(8'hD0, ack); check("rd_dev_w_ack", 32'(ack), 32'(ACK));
        send_byte(8'h20, ack); check("rd_reg_ack", 32'(ack), 32'(ACK));
        i2c_rep_start();
        exp_rd_q.push_back(8'h20); exp_rd_q.push_back(8'h21);
        send_byte(8'hD1, ack); check("rd_dev_r_ack", 32'(ack), 32'(ACK));
        read_byte(ACK, rdata);  check("rd_byte0", 32'(rdata), 32'(exp_data_q.pop_front()));
        read_byte(NACK, rdata); check("rd_byte1", 32'(rdata), 32'(exp_data_q.pop_front()));
        check("rd_sda_released", 32'(sda_low), 32'd0);
        check("rd_state_ignore", 32'(dbg_state), 32'(ST_IGNORE));
        i2c_stop();
        check("rd_enables", 32'(rd_cnt - rd0), 32'd2);
        check("rd_no_write", 32'(wr_cnt - wr0), 32'd0);
        check("rd_ptr", 32'(reg_addr), 32'h21);

        // Foreign address: never acknowledged, never driven
        wr0 = wr_cnt; rd0 = rd_cnt; dv0 = drv_cnt; st0 = stop_cnt;
        i2c_start();
        send_byte(8'hA0, ack); check("foreign_nack", 32'(ack), 32'(NACK));
        send_byte(8'h55, ack); check("foreign_nack2", 32'(ack), 32'(NACK));
        check("foreign_busy", 32'(busy), 32'd0);
        i2c_stop();
        check("foreign_drive", 32'(drv_cnt - dv0), 32'd0);
        check("foreign_pulses", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
        check("foreign_stop", 32'(stop_cnt - st0), 32'd1);

        // Partial register byte cut off by STOP
        wr0 = wr_cnt;
        i2c_start();
        send_byte(8'hD0, ack); check("partial_dev_ack", 32'(ack), 32'(ACK));
        send_bit(1'b1, ack); send_bit(1'b0, ack); send_bit(1'b1, ack); send_bit(1'b0, ack);
        i2c_stop();
        check("partial_ptr", 32'(reg_addr), 32'h21);
        check("partial_no_write", 32'(wr_cnt - wr0), 32'd0);
        check("partial_state", 32'(dbg_state), 32'(ST_IDLE));

        // Reset asserted while the target is driving a 0 data bit
        mem[8'h40] = 8'h00;
        i2c_start();
        send_byte(8'hD0, ack); send_byte(8'h40, ack);
        i2c_rep_start();
        exp_rd_q.push_back(8'h40);
        send_byte(8'hD1, ack); check("mid_rd_ack", 32'(ack), 32'(ACK));
        check("mid_rd_driving", 32'(sda_low), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_sda", 32'(sda_low), 32'd0);
        check("mid_rst_ptr", 32'(reg_addr), 32'h00);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pulses", 32'({reg_we, reg_re, stop_det}), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        scl = 1'b1; sda_ctrl = 1'b1;
        repeat (4) @(posedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
